// File: rtl/divider_sequential.sv
// Iterative 32-bit radix-2 restoring divider with a valid/ready handshake and 33-edge latency.
// Optional two's-complement operation is enabled by defining DIVIDER_SIGNED_EN.
module divider_sequential (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        valid_out,
    output logic [31:0] q,
    output logic [31:0] rem,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  count;
    logic [31:0] prem;
    logic [31:0] qreg;
    logic [31:0] divisor;
    logic        b_zero;

    logic [32:0] shifted;
    logic        ge;
    logic [31:0] prem_nxt;
    logic [31:0] qreg_nxt;
    logic [31:0] q_final;
    logic [31:0] rem_final;
    logic [31:0] a_load;
    logic [31:0] b_load;

`ifdef DIVIDER_SIGNED_EN
    logic        neg_q;
    logic        neg_r;
    logic [31:0] a_raw;

    // Magnitudes; |0x8000_0000| is still 0x8000_0000 when read as unsigned.
    always_comb begin
        a_load = a[31] ? (~a + 32'd1) : a;
        b_load = b[31] ? (~b + 32'd1) : b;
    end
`else
    always_comb begin
        a_load = a;
        b_load = b;
    end
`endif

    // The shifted partial remainder can need 33 bits when the divisor MSB is set.
    always_comb begin
        shifted  = {prem, qreg[31]};
        ge       = shifted >= {1'b0, divisor};
        prem_nxt = ge ? (shifted[31:0] - divisor) : shifted[31:0];
        qreg_nxt = {qreg[30:0], ge};
    end

`ifdef DIVIDER_SIGNED_EN
    always_comb begin
        if (b_zero) begin
            q_final   = 32'hFFFF_FFFF;
            rem_final = a_raw;
        end else begin
            q_final   = neg_q ? (~qreg_nxt + 32'd1) : qreg_nxt;
            rem_final = neg_r ? (~prem_nxt + 32'd1) : prem_nxt;
        end
    end
`else
    always_comb begin
        q_final   = qreg_nxt;
        rem_final = prem_nxt;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (valid_in) state_nxt = CALC;
            CALC:    if (count == 5'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready_in  = (state == IDLE);
        valid_out = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= 5'd0;
            prem        <= 32'd0;
            qreg        <= 32'd0;
            divisor     <= 32'd0;
            b_zero      <= 1'b0;
            q           <= 32'd0;
            rem         <= 32'd0;
            div_by_zero <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            a_raw       <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        divisor <= b_load;
                        b_zero  <= ~|b;
                        prem    <= 32'd0;
                        qreg    <= a_load;
                        count   <= 5'd31;
`ifdef DIVIDER_SIGNED_EN
                        neg_q   <= a[31] ^ b[31];
                        neg_r   <= a[31];
                        a_raw   <= a;
`endif
                    end
                end
                CALC: begin
                    prem <= prem_nxt;
                    qreg <= qreg_nxt;
                    if (count == 5'd0) begin
                        q           <= q_final;
                        rem         <= rem_final;
                        div_by_zero <= b_zero;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
